// File: rtl/note_game_pkg.sv
// Shared game encodings and lane constants for the rhythm-game judge.
package note_game_pkg;

  localparam int NUM_LANES = 3;
  localparam int LANE_R    = 2;
  localparam int LANE_G    = 1;
  localparam int LANE_B    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b11
  } game_state_e;

  function automatic logic [1:0] lane_count(input logic [NUM_LANES-1:0] mask);
    lane_count = {1'b0, mask[LANE_R]} + {1'b0, mask[LANE_G]} + {1'b0, mask[LANE_B]};
  endfunction

endpackage

// File: rtl/note_hit_judge_lane_debouncer.sv
// One lane button: 2-FF synchronizer, stable-count debouncer, registered press strobe.
module lane_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic board_clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Press strobe is registered alongside the level flip so the judge sees it next cycle.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/note_hit_judge.sv
// Hit/miss judge and score keeper for the three-lane rhythm game.
// Optional ghost-press penalty: define NOTE_HIT_JUDGE_GHOST_PENALTY_EN.
module note_hit_judge
  import note_game_pkg::*;
#(
  parameter int TARGET_Y        = 400,
  parameter int WINDOW          = 12,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCORE_MAX       = 99,
  parameter int MISS_MAX        = 10
) (
  input  logic                 board_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_LANES-1:0] btn_lane,
  input  logic                 note_new,
  input  logic [NUM_LANES-1:0] note_lanes,
  input  logic [9:0]           note_y,
  output logic [6:0]           score,
  output logic [3:0]           miss_count,
  output logic [1:0]           state,
  output logic [NUM_LANES-1:0] hit_pulse,
  output logic                 miss_pulse
);

  localparam logic [10:0] WIN_HI    = 11'(TARGET_Y + WINDOW);
  localparam logic [10:0] WIN_LO    = (TARGET_Y > WINDOW) ? 11'(TARGET_Y - WINDOW) : 11'd0;
  localparam logic [7:0]  SCORE_LIM = 8'(SCORE_MAX);
  localparam logic [4:0]  MISS_LIM  = 5'(MISS_MAX);

  game_state_e          r_state;
  logic                 r_start_s1;
  logic                 r_start_s2;
  logic [6:0]           r_score;
  logic [3:0]           r_miss;
  logic [NUM_LANES-1:0] r_pending;
  logic [NUM_LANES-1:0] r_hit_pulse;
  logic                 r_miss_pulse;

  logic [NUM_LANES-1:0] w_press;
  logic [10:0]          w_y;
  logic                 w_in_win;
  logic                 w_late;
  logic [NUM_LANES-1:0] w_hit;
  logic                 w_note_miss;
  logic                 w_ghost;
  logic                 w_miss;
  logic [7:0]           w_score_sum;
  logic [6:0]           w_score_nx;
  logic [4:0]           w_miss_sum;
  logic [3:0]           w_miss_nx;
  logic [NUM_LANES-1:0] w_pend_nx;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .board_clk(board_clk),
      .reset    (reset),
      .i_btn    (btn_lane[l]),
      .o_press  (w_press[l])
    );
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
    end
  end

  always_comb begin
    w_y         = {1'b0, note_y};
    w_in_win    = (w_y >= WIN_LO) && (w_y <= WIN_HI);
    w_late      = (w_y > WIN_HI);
    w_hit       = w_press & r_pending & {NUM_LANES{w_in_win}};
    w_note_miss = (|r_pending) && w_late;
`ifdef NOTE_HIT_JUDGE_GHOST_PENALTY_EN
    w_ghost     = |(w_press & ~w_hit);
`else
    w_ghost     = 1'b0;
`endif
    // A late note and a ghost press in the same cycle still count as one miss.
    w_miss      = w_note_miss | w_ghost;

    w_score_sum = {1'b0, r_score} + 8'(lane_count(w_hit));
    w_score_nx  = (w_score_sum >= SCORE_LIM) ? SCORE_LIM[6:0] : w_score_sum[6:0];
    w_miss_sum  = {1'b0, r_miss} + 5'(w_miss);
    w_miss_nx   = (w_miss_sum >= MISS_LIM) ? MISS_LIM[3:0] : w_miss_sum[3:0];

    // Miss clears against the old mask first; a new note then overwrites it.
    w_pend_nx = r_pending & ~w_hit;
    if (w_note_miss) w_pend_nx = '0;
    if (note_new)    w_pend_nx = note_lanes;
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_score      <= '0;
      r_miss       <= '0;
      r_pending    <= '0;
      r_hit_pulse  <= '0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_hit_pulse  <= '0;
      r_miss_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_start_s2) begin
            r_state   <= ST_PLAY;
            r_score   <= '0;
            r_miss    <= '0;
            r_pending <= '0;
          end
        end
        ST_PLAY: begin
          if (!r_start_s2) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
          end else begin
            r_hit_pulse  <= w_hit;
            r_miss_pulse <= w_miss;
            r_score      <= w_score_nx;
            r_miss       <= w_miss_nx;
            r_pending    <= w_pend_nx;
            if ((8'(w_score_nx) == SCORE_LIM) || (5'(w_miss_nx) == MISS_LIM)) begin
              r_state   <= ST_DONE;
              r_pending <= '0;
            end
          end
        end
        ST_DONE: begin
          if (!r_start_s2) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign score      = r_score;
  assign miss_count = r_miss;
  assign state      = r_state;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;

endmodule

// File: tb/tb_note_hit_judge.sv
// Scoreboard bench for note_hit_judge with a short debounce time.
module tb_note_hit_judge;

  logic       board_clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] btn_lane;
  logic       note_new;
  logic [2:0] note_lanes;
  logic [9:0] note_y;
  logic [6:0] score;
  logic [3:0] miss_count;
  logic [1:0] state;
  logic [2:0] hit_pulse;
  logic       miss_pulse;

  note_hit_judge #(
    .TARGET_Y       (400),
    .WINDOW         (12),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .start     (start),
    .btn_lane  (btn_lane),
    .note_new  (note_new),
    .note_lanes(note_lanes),
    .note_y    (note_y),
    .score     (score),
    .miss_count(miss_count),
    .state     (state),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse)
  );

  always #5 board_clk = ~board_clk;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  hit;
    logic        miss;
    logic [6:0]  score;
    logic [3:0]  misses;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned es = 0;
  int unsigned em = 0;

  always @(posedge board_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge board_clk) begin
    exp_t e;
    if (!reset && (hit_pulse != 3'b000 || miss_pulse)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {28'd0, hit_pulse, miss_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("hit_pulse", {29'd0, hit_pulse}, {29'd0, e.hit});
        check("miss_pulse", {31'd0, miss_pulse}, {31'd0, e.miss});
        check("score_at_pulse", {25'd0, score}, {25'd0, e.score});
        check("misses_at_pulse", {28'd0, miss_count}, {28'd0, e.misses});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  task automatic load_note(input logic [2:0] lanes, input logic [9:0] y);
    note_lanes = lanes;
    note_y     = y;
    note_new   = 1'b1;
    tick(1);
    note_new   = 1'b0;
  endtask

  task automatic press(input logic [2:0] b, input logic [2:0] exp_hit, input logic ghost);
    exp_t e;
    logic g;
`ifdef NOTE_HIT_JUDGE_GHOST_PENALTY_EN
    g = ghost;
`else
    g = 1'b0;
`endif
    btn_lane = b;
    if (exp_hit != 3'b000 || g) begin
      es = es + exp_hit[0] + exp_hit[1] + exp_hit[2];
      em = em + g;
      e.cyc = cyc + 7; e.hit = exp_hit; e.miss = g;
      e.score = 7'(es); e.misses = 4'(em);
      sb.push_back(e);
    end
    tick(12);
    btn_lane = 3'b000;
    tick(10);
  endtask

  task automatic step_y(input logic [9:0] y, input logic exp_miss);
    exp_t e;
    note_y = y;
    if (exp_miss) begin
      em++;
      e.cyc = cyc + 1; e.hit = 3'b000; e.miss = 1'b1;
      e.score = 7'(es); e.misses = 4'(em);
      sb.push_back(e);
    end
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; btn_lane = 3'b000;
    note_new = 1'b0; note_lanes = 3'b000; note_y = 10'd0;
    tick(2);
    check("rst_score", {25'd0, score}, 32'd0);
    check("rst_miss", {28'd0, miss_count}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_hit", {29'd0, hit_pulse}, 32'd0);
    check("rst_misspulse", {31'd0, miss_pulse}, 32'd0);
    reset = 1'b0;
    tick(2);

    start = 1'b1;
    tick(2);
    check("start_edge2", {30'd0, state}, 32'd0);
    tick(1);
    check("start_edge3", {30'd0, state}, 32'd1);

    load_note(3'b100, 10'd395);
    press(3'b100, 3'b100, 1'b0);
    check("clean_hit_score", {25'd0, score}, 32'd1);

    load_note(3'b011, 10'd100);
    step_y(10'd412, 1'b0);
    step_y(10'd413, 1'b1);
    step_y(10'd414, 1'b0);
    check("miss_count_1", {28'd0, miss_count}, 32'd1);

    load_note(3'b001, 10'd400);
    for (int i = 0; i < 6; i++) begin
      btn_lane = 3'b001; tick(2);
      btn_lane = 3'b000; tick(2);
    end
    tick(8);
    check("bounce_score", {25'd0, score}, 32'd1);

    load_note(3'b111, 10'd388);
    press(3'b111, 3'b111, 1'b0);
    check("chord_score", {25'd0, score}, 32'd4);

    load_note(3'b010, 10'd387);
    press(3'b010, 3'b000, 1'b1);
    check("below_window_score", {25'd0, score}, 32'd4);

    load_note(3'b000, 10'd400);
    press(3'b001, 3'b000, 1'b1);
    check("ghost_miss", {28'd0, miss_count}, em);

    while (em < 10) begin
      load_note(3'b001, 10'd100);
      step_y(10'd413, 1'b1);
    end
    check("done_state", {30'd0, state}, 32'd3);
    load_note(3'b001, 10'd100);
    step_y(10'd413, 1'b0);
    check("done_miss_hold", {28'd0, miss_count}, 32'd10);
    check("done_score_hold", {25'd0, score}, 32'd4);

    start = 1'b0;
    tick(3);
    check("abort_state", {30'd0, state}, 32'd0);
    start = 1'b1;
    tick(3);
    es = 0; em = 0;
    check("restart_state", {30'd0, state}, 32'd1);
    check("restart_score", {25'd0, score}, 32'd0);
    check("restart_miss", {28'd0, miss_count}, 32'd0);

    load_note(3'b001, 10'd400);
    btn_lane = 3'b001;
    tick(5);
    reset = 1'b1;
    #1;
    check("midrst_state", {30'd0, state}, 32'd0);
    check("midrst_hit", {29'd0, hit_pulse}, 32'd0);
    check("midrst_misspulse", {31'd0, miss_pulse}, 32'd0);
    tick(4);
    btn_lane = 3'b000;
    reset = 1'b0;
    tick(12);
    check("post_rst_state", {30'd0, state}, 32'd1);
    check("post_rst_score", {25'd0, score}, 32'd0);
    check("sb_drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
